// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide sequencer: op encoding, FSM states,
// default latencies and the mult/div classification helper.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MFHI    = 4'd7,
    MFLO    = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int DEFAULT_MULT_LAT = 5;
  localparam int DEFAULT_DIV_LAT  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32-bit multiply/divide datapath producing the HI/LO pair,
// including divide-by-zero and signed-overflow corner cases.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic        [31:0] w_safe_b;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquo;
  logic        [31:0] w_urem;

  assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_umul = {32'd0, i_a} * {32'd0, i_b};

  assign w_div_zero = (i_b == 32'd0);
  assign w_div_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // The dividers never see a zero or overflowing divisor; those cases are muxed below.
  assign w_safe_b = (w_div_zero || w_div_ovf) ? 32'd1 : i_b;
  assign w_squo   = $signed(i_a) / $signed(w_safe_b);
  assign w_srem   = $signed(i_a) % $signed(w_safe_b);
  assign w_uquo   = i_a / w_safe_b;
  assign w_urem   = i_a % w_safe_b;

  // Select the HI/LO pair for the requested operation.
  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    case (i_op)
      MULT: begin
        o_hi = w_smul[63:32];
        o_lo = w_smul[31:0];
      end
      MULTU: begin
        o_hi = w_umul[63:32];
        o_lo = w_umul[31:0];
      end
      DIV: begin
        if (w_div_zero) begin
          o_hi = i_a;
          o_lo = 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
          o_hi = 32'd0;
          o_lo = 32'h8000_0000;
        end else begin
          o_hi = w_srem;
          o_lo = w_squo;
        end
      end
      DIVU: begin
        if (w_div_zero) begin
          o_hi = i_a;
          o_lo = 32'hFFFF_FFFF;
        end else begin
          o_hi = w_urem;
          o_lo = w_uquo;
        end
      end
      default: begin
        o_hi = 32'd0;
        o_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, holds a computed result for
// a programmed latency and then commits it, reporting Start/Busy to the stall logic.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_LAT = DEFAULT_MULT_LAT,
  parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  md_state_e   r_state;
  md_state_e   w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [31:0] w_arith_hi;
  logic [31:0] w_arith_lo;
  logic        w_accept;
  logic        w_start;
  logic        w_commit;

  md_arith u_arith (
    .i_op (md_op),
    .i_a  (rs_data),
    .i_b  (rt_data),
    .o_hi (w_arith_hi),
    .o_lo (w_arith_lo)
  );

  assign busy     = (r_state == ST_RUN);
  assign w_accept = op_valid & ~cancel & ~busy;
  assign w_start  = w_accept & is_muldiv(md_op);
  assign start    = w_start;
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Next-state, countdown and commit decision.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_RUN;
          w_cnt_next   = ((md_op == MULT) || (md_op == MULTU)) ? MULT_CNT : DIV_CNT;
        end
      end
      ST_RUN: begin
        if (r_cnt == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and countdown registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the result at Start; operands are not looked at again afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else if (w_start) begin
      r_pend_hi <= w_arith_hi;
      r_pend_lo <= w_arith_lo;
    end
  end

  // Architectural HI/LO: committed results or direct moves from rs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= r_pend_hi;
      r_lo <= r_pend_lo;
    end else begin
      if (w_accept && (md_op == MTHI)) r_hi <= rs_data;
      if (w_accept && (md_op == MTLO)) r_lo <= rs_data;
    end
  end

  // Move-from read port; not gated by cancel or busy.
  always_comb begin
    md_rdata = 32'd0;
    if (op_valid && (md_op == MFHI)) md_rdata = r_hi;
    if (op_valid && (md_op == MFLO)) md_rdata = r_lo;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: table vectors, hand-written corner
// sequences and a randomized phase against a cycle-indexed reference model.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic        cancel = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sequencer #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .md_op    (md_op),
    .cancel   (cancel),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .start    (start),
    .busy     (busy),
    .md_rdata (md_rdata),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the result becomes architectural at an absolute cycle index.
  int          cyc = 0;
  logic        m_active = 1'b0;
  int          m_done = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;

  logic        obs_start, obs_busy;
  logic [31:0] obs_rdata, obs_hi, obs_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic ref_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    rh = 32'd0;
    rl = 32'd0;
    if (op == MULT) begin
      p = sa * sb;
      rh = p[63:32]; rl = p[31:0];
    end else if (op == MULTU) begin
      p = ua * ub;
      rh = p[63:32]; rl = p[31:0];
    end else if (b == 32'd0) begin
      rh = a; rl = 32'hFFFF_FFFF;
    end else if (op == DIV) begin
      q = sa / sb; r = sa % sb;
      p = q; rl = p[31:0];
      p = r; rh = p[31:0];
    end else begin
      uq = ua / ub; ur = ua % ub;
      rl = uq[31:0]; rh = ur[31:0];
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic step(input logic v, input logic [3:0] op, input logic c,
                      input logic [31:0] a, input logic [31:0] b);
    logic        e_start;
    logic [31:0] e_rdata;
    logic        md;
    op_valid = v; md_op = op; cancel = c; rs_data = a; rt_data = b;
    @(negedge clk);
    if (m_active && cyc >= m_done) begin
      m_hi = m_phi; m_lo = m_plo; m_active = 1'b0;
    end
    md = (op >= 4'd1) && (op <= 4'd4);
    e_start = v & ~c & ~m_active & md;
    e_rdata = (v && op == MFHI) ? m_hi : (v && op == MFLO) ? m_lo : 32'd0;
    obs_start = start; obs_busy = busy; obs_rdata = md_rdata; obs_hi = hi; obs_lo = lo;
    chk("start", {31'd0, start}, {31'd0, e_start});
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("md_rdata", md_rdata, e_rdata);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(posedge clk);
    if (e_start) begin
      ref_arith(op, a, b, m_phi, m_plo);
      m_active = 1'b1;
      m_done = cyc + (((op == MULT) || (op == MULTU)) ? ML : DL) + 1;
    end else if (v && !c && !m_active) begin
      if (op == MTHI) m_hi = a;
      if (op == MTLO) m_lo = a;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    int lat, nb;
    logic [31:0] prev_hi;
    logic found;

    vecs[0] = '{MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[4] = '{DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    // Reset state while reset is held low.
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven mult/div vectors.
    for (int i = 0; i < 6; i++) begin
      lat = ((vecs[i].op == MULT) || (vecs[i].op == MULTU)) ? ML : DL;
      prev_hi = m_hi;
      step(1'b1, vecs[i].op, 1'b0, vecs[i].rs, vecs[i].rt);
      chk("vec_start", {31'd0, obs_start}, 32'd1);
      nb = 0;
      for (int k = 1; k <= lat + 1; k++) begin
        idle();
        nb += int'(obs_busy);
        if (k == lat) chk("vec_hold_hi", obs_hi, prev_hi);
      end
      chk("vec_busy_len", nb, lat);
      chk("vec_hi", obs_hi, vecs[i].hi);
      chk("vec_lo", obs_lo, vecs[i].lo);
      $display("vec %0d op=%0d rs=%h rt=%h -> hi=%h lo=%h busy=%0d", i, vecs[i].op,
               vecs[i].rs, vecs[i].rt, obs_hi, obs_lo, nb);
    end

    // MTHI with cancel is dropped; without cancel it lands next cycle.
    prev_hi = m_hi;
    step(1'b1, MTHI, 1'b1, 32'h1234, 32'd0);
    idle();
    chk("mthi_cancel", obs_hi, prev_hi);
    step(1'b1, MTHI, 1'b0, 32'h1234, 32'd0);
    idle();
    chk("mthi", obs_hi, 32'h1234);
    $display("seq mthi: cancelled hi=%h, then hi=%h", prev_hi, obs_hi);

    // MULT with cancel: no start, no busy.
    step(1'b1, MULT, 1'b1, 32'd9, 32'd9);
    chk("mult_cancel_start", {31'd0, obs_start}, 32'd0);
    idle();
    chk("mult_cancel_busy", {31'd0, obs_busy}, 32'd0);
    $display("seq cancel mult: start=%0d busy=%0d", 1'b0, obs_busy);

    // MULTU while busy is ignored; result belongs to the first op.
    step(1'b1, MULT, 1'b0, 32'd2, 32'd3);
    step(1'b1, MULTU, 1'b0, 32'd5, 32'd7);
    chk("busy_ignore_start", {31'd0, obs_start}, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      idle();
      if (!obs_busy) found = 1'b1;
    end
    chk("busy_ignore_done", {31'd0, found}, 32'd1);
    chk("busy_ignore_hi", obs_hi, 32'd0);
    chk("busy_ignore_lo", obs_lo, 32'd6);
    $display("seq overlap: hi=%h lo=%h", obs_hi, obs_lo);

    // MFLO during busy returns old LO, new LO the cycle busy drops.
    step(1'b1, MULT, 1'b0, 32'd4, 32'd5);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(1'b1, MFLO, 1'b0, 32'd0, 32'd0);
      if (obs_busy) chk("mflo_old", obs_rdata, 32'd6);
      else begin
        chk("mflo_new", obs_rdata, 32'd20);
        found = 1'b1;
      end
    end
    chk("mflo_done", {31'd0, found}, 32'd1);
    $display("seq mflo: final rdata=%h", obs_rdata);

    // Async reset in the third busy cycle of a DIV.
    step(1'b1, DIV, 1'b0, 32'd1000, 32'd3);
    idle();
    idle();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    m_active = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < DL + 3; k++) idle();
    chk("arst_no_commit_hi", obs_hi, 32'd0);
    chk("arst_no_commit_lo", obs_lo, 32'd0);
    $display("seq async reset: hi=%h lo=%h", obs_hi, obs_lo);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      logic [3:0] op;
      op = 4'($urandom_range(0, 8));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      step($urandom_range(0, 3) != 0, op, $urandom_range(0, 7) == 0, a, b);
      if (obs_start) $display("rand start op=%0d rs=%h rt=%h", op, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
